// File: rtl/shared_alu_arb.sv
// rtl/shared_alu_arb.sv - two-requester round-robin arbiter for a shared ALU with a one-entry result buffer
`ifndef SRC_A_SEL_WIDTH
`define SRC_A_SEL_WIDTH 2
`endif
`ifndef SRC_B_SEL_WIDTH
`define SRC_B_SEL_WIDTH 2
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif

module shared_alu_arb #(
  parameter int RR_INIT = 0
) (
  input  logic                          clk,
  input  logic                          reset_x,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  logic [2*`SRC_A_SEL_WIDTH-1:0] req_src_a_sel,
  input  logic [2*`SRC_B_SEL_WIDTH-1:0] req_src_b_sel,
  input  logic [2*`ALU_OP_WIDTH-1:0]    req_alu_op,
  input  logic [2*`ADDR_LEN-1:0]        req_pc,
  input  logic [2*`DATA_LEN-1:0]        req_rs1,
  input  logic [2*`DATA_LEN-1:0]        req_rs2,
  input  logic [2*`DATA_LEN-1:0]        req_imm,
  output logic [`SRC_A_SEL_WIDTH-1:0]   src_a_sel,
  output logic [`SRC_B_SEL_WIDTH-1:0]   src_b_sel,
  output logic [`ALU_OP_WIDTH-1:0]      alu_op,
  output logic [`ADDR_LEN-1:0]          pc,
  output logic [`DATA_LEN-1:0]          rs1,
  output logic [`DATA_LEN-1:0]          rs2,
  output logic [`DATA_LEN-1:0]          imm,
  input  logic [`DATA_LEN-1:0]          alu_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [`DATA_LEN-1:0]          out_data,
  output logic                          out_id
);

  localparam int AW = `SRC_A_SEL_WIDTH;
  localparam int BW = `SRC_B_SEL_WIDTH;
  localparam int OW = `ALU_OP_WIDTH;
  localparam int DW = `DATA_LEN;
  localparam int PW = `ADDR_LEN;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

  buf_state_t     state_q, state_d;
  logic [DW-1:0]  out_data_q, out_data_d;
  logic           out_id_q, out_id_d;
  logic           prio_q, prio_d;
  logic           can_acc;
  logic           grant;
  logic           accept;

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign can_acc   = !out_valid || out_ready;

  // Grant selection: lone requester wins, contention resolved by the priority bit
  always_comb begin
    grant = 1'b0;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = prio_q;
      default: grant = 1'b0;
    endcase
  end

  // Handshake: only the granted requester sees ready, and never while in reset
  always_comb begin
    req_ready = 2'b00;
    if (reset_x && can_acc) begin
      req_ready[0] = req_valid[0] && !grant;
      req_ready[1] = req_valid[1] &&  grant;
    end
  end

  assign accept = |req_ready;

  // Operand steering: granted requester's fields drive the shared datapath, zero when idle
  always_comb begin
    src_a_sel = '0;
    src_b_sel = '0;
    alu_op    = '0;
    pc        = '0;
    rs1       = '0;
    rs2       = '0;
    imm       = '0;
    if (|req_valid) begin
      src_a_sel = grant ? req_src_a_sel[2*AW-1:AW] : req_src_a_sel[AW-1:0];
      src_b_sel = grant ? req_src_b_sel[2*BW-1:BW] : req_src_b_sel[BW-1:0];
      alu_op    = grant ? req_alu_op[2*OW-1:OW]    : req_alu_op[OW-1:0];
      pc        = grant ? req_pc[2*PW-1:PW]        : req_pc[PW-1:0];
      rs1       = grant ? req_rs1[2*DW-1:DW]       : req_rs1[DW-1:0];
      rs2       = grant ? req_rs2[2*DW-1:DW]       : req_rs2[DW-1:0];
      imm       = grant ? req_imm[2*DW-1:DW]       : req_imm[DW-1:0];
    end
  end

  // Buffer next state: capture on accept, drain when consumer takes it, otherwise hold
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    prio_d     = prio_q;
    if (accept) begin
      out_data_d = alu_out;
      out_id_d   = grant;
      prio_d     = ~grant;
    end
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (!accept && out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // State registers with synchronous active-low reset discarding any buffered result
  always_ff @(posedge clk) begin
    if (!reset_x) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_id_q   <= 1'b0;
      prio_q     <= 1'(RR_INIT);
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      prio_q     <= prio_d;
    end
  end

endmodule

// File: doc/shared_alu_arb.md
SHARED_ALU_ARB -- requirements
Module: shared_alu_arb

Interface
REQ-001 Parameter: RR_INIT, default 0, requester holding priority after reset (0 or 1).
REQ-002 Widths SHALL come from the codebase constants: `SRC_A_SEL_WIDTH, `SRC_B_SEL_WIDTH, `ALU_OP_WIDTH, `DATA_LEN, `ADDR_LEN.
REQ-003 Clocking SHALL be one clock, with a synchronous, active-low reset.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset_x  in  1  synchronous reset, active-low.
REQ-006 req_valid  in  2  bit i: requester i presents an ALU operation.
REQ-007 req_ready  out  2  bit i: requester i's operation is accepted this cycle.
REQ-008 req_src_a_sel  in  2*SRC_A_SEL_WIDTH  per-requester A-source select; requester i in slice i.
REQ-009 req_src_b_sel  in  2*SRC_B_SEL_WIDTH  per-requester B-source select.
REQ-010 req_alu_op  in  2*ALU_OP_WIDTH  per-requester ALU opcode.
REQ-011 req_pc  in  2*ADDR_LEN  per-requester PC operand.
REQ-012 req_rs1 / req_rs2 / req_imm  in  2*DATA_LEN each  per-requester register and immediate operands.
REQ-013 src_a_sel  out  SRC_A_SEL_WIDTH  to the A-source mux.
REQ-014 src_b_sel  out  SRC_B_SEL_WIDTH  to the B-source mux.
REQ-015 alu_op  out  ALU_OP_WIDTH  to the ALU.
REQ-016 pc / rs1 / rs2 / imm  out  ADDR_LEN / DATA_LEN  operands to the source muxes.
REQ-017 alu_out  in  DATA_LEN  combinational ALU result for the driven operation.
REQ-018 out_valid  out  1  registered result available.
REQ-019 out_ready  in  1  consumer takes the result this cycle.
REQ-020 out_data  out  DATA_LEN  registered result.
REQ-021 out_id  out  1  index of the requester that produced out_data.

Function
REQ-022 can_acc SHALL equal !out_valid || out_ready.
REQ-023 Grant g: if exactly one req_valid bit is set, g SHALL be that bit; if both are set, g SHALL be prio; if neither is set, the grant is undefined and nothing is accepted.
REQ-024 req_ready[i] SHALL equal can_acc && req_valid[i] && (g==i); the path is combinational, and at most one bit is set per cycle.
REQ-025 Accept SHALL occur when req_valid[g] && can_acc in the same cycle.
REQ-026 When any req_valid bit is set, the mux and ALU outputs (REQ-013..016) SHALL carry requester g's fields combinationally; when none is set, they SHALL be all-zero.
REQ-027 On accept: out_data<=alu_out, out_id<=g, out_valid<=1; latency from accept edge to out_valid is 1 cycle.
REQ-028 With no accept and out_ready=1: out_valid<=0.
REQ-029 With no accept and out_ready=0: out_valid, out_data and out_id SHALL hold.
REQ-030 Output-buffer FSM: EMPTY (out_valid=0) and FULL (out_valid=1). EMPTY->FULL on accept. FULL->EMPTY on out_ready && !accept. FULL->FULL on stall, or on drain and accept in the same cycle (new data).
REQ-031 Sustained throughput SHALL be 1 operation/cycle while out_ready=1.
REQ-032 Round-robin: on accept from requester i, prio<=~i; otherwise prio holds.
REQ-033 Fairness: a requester holding req_valid SHALL be accepted within 2 accepts.
REQ-034 Requesters SHALL hold their payload stable while valid && !ready; the block does not check this.
REQ-035 out_data SHALL change only on accept.

Reset
REQ-036 While reset_x=0 at a clock edge: out_valid<=0, out_data<=0, out_id<=0, prio<=RR_INIT.
REQ-037 While reset_x=0, req_ready SHALL be 2'b00 combinationally, and no accept occurs.
REQ-038 A reset in FULL SHALL discard the buffered result; the first cycle after reset is EMPTY.

Verification
REQ-039 Reset, RR_INIT=0, req_valid=2'b11, out_ready=1, alu_out tracks operands -> accept order 0,1,0,1, one per cycle; out_id follows one cycle later.
REQ-040 Requester 0 only: src_a_sel=PC, src_b_sel=FOUR, pc=0x100 -> src_a_sel/src_b_sel outputs reflect the request, req_ready=01, next cycle out_valid=1, out_data=0x104, out_id=0.
REQ-041 FULL with out_ready=0 for 3 cycles, req_valid=2'b01 -> req_ready=0 throughout; out_data held; on out_ready=1 the drain and a new accept occur in the same cycle.
REQ-042 FULL, out_ready=1, req_valid=0 -> out_valid=0 next cycle; out_data unchanged.
REQ-043 reset_x=0 asserted while FULL and both requesting -> req_ready=00; after release out_valid=0 and prio=RR_INIT.
REQ-044 Requester 1 continuous, requester 0 asserts mid-stream -> requester 0 accepted within 2 accepts.
